// File: rtl/ram_arbiter.sv
// ram_arbiter: two-client round-robin arbiter that serialises read/write
// commands onto one single-port RAM and returns read data to the owner.
// A watchdog bounds the time spent waiting for the RAM's read-valid.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  r0_req,
    input  logic                  r0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic                  r0_rerr,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic                  r1_rerr,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_rd,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_out_en,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t                state_q;
    logic                  ptr_q;      // client that wins a tie
    logic                  owner_q;    // client owning the in-flight command
    logic [CW-1:0]         cnt_q;
    logic                  gnt0_q, gnt1_q, rv0_q, rv1_q, re0_q, re1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    logic                  en_q, wr_q, busy_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    // Winner selection from the live requests; only consumed in IDLE.
    logic win_vld_d, win_d;
    always_comb begin
        win_vld_d = r0_req | r1_req;
        win_d     = (r0_req && r1_req) ? ptr_q : r1_req;
    end

    // Sequencer FSM: grant in IDLE, one-cycle write, or read with watchdog.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            re0_q    <= 1'b0;
            re1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses.
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            re0_q  <= 1'b0;
            re1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        en_q    <= 1'b1;
                        addr_q  <= win_d ? r1_addr  : r0_addr;
                        wr_q    <= win_d ? r1_wr_rd : r0_wr_rd;
                        din_q   <= win_d ? r1_wdata : r0_wdata;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        ptr_q   <= ~win_d;
                        owner_q <= win_d;
                        busy_q  <= 1'b1;
                        state_q <= (win_d ? r1_wr_rd : r0_wr_rd) ? WR : RD;
                    end else begin
                        en_q <= 1'b0;
                    end
                end
                WR: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                RD: begin
                    // Data beats the watchdog when both land on the same edge.
                    if (ram_out_en) begin
                        if (owner_q) begin
                            rdata1_q <= ram_data_out;
                            rv1_q    <= 1'b1;
                        end else begin
                            rdata0_q <= ram_data_out;
                            rv0_q    <= 1'b1;
                        end
                        en_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (owner_q) begin
                            rdata1_q <= '0;
                            re1_q    <= 1'b1;
                        end else begin
                            rdata0_q <= '0;
                            re0_q    <= 1'b1;
                        end
                        en_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r0_gnt      = gnt0_q;
    assign r1_gnt      = gnt1_q;
    assign r0_rvalid   = rv0_q;
    assign r1_rvalid   = rv1_q;
    assign r0_rerr     = re0_q;
    assign r1_rerr     = re1_q;
    assign r0_rdata    = rdata0_q;
    assign r1_rdata    = rdata1_q;
    assign ram_en      = en_q;
    assign ram_addr    = addr_q;
    assign ram_wr_rd   = wr_q;
    assign ram_data_in = din_q;
    assign busy        = busy_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one single-port RAM (`ram` module).
- Accepts independent read/write commands from two clients and serialises them onto the RAM's en/addr/wr_rd/data_in interface.
- For reads, waits for the RAM's out_en and returns the data to the owning client; a watchdog counter guards against a missing out_en.

Parameters:
- DATA_WIDTH, `data_width, RAM data width.
- ADDR_WIDTH, `addr_width, RAM address width.
- TIMEOUT, 8, max cycles spent in RD waiting for ram_out_en (must be >= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- r0_req  input  1  client 0 command request; held with its command fields until r0_gnt.
- r0_wr_rd  input  1  client 0 command type: 1 = write, 0 = read.
- r0_addr  input  ADDR_WIDTH  client 0 address.
- r0_wdata  input  DATA_WIDTH  client 0 write data.
- r0_gnt  output  1  one-cycle pulse: client 0 command accepted.
- r0_rvalid  output  1  one-cycle pulse: r0_rdata valid.
- r0_rerr  output  1  one-cycle pulse: client 0 read timed out.
- r0_rdata  output  DATA_WIDTH  client 0 read data; holds its value until the next client 0 read completes.
- r1_*  same eight ports as r0_*, for client 1.
- ram_en  output  1  RAM enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wr_rd  output  1  RAM write (1) / read (0).
- ram_data_in  output  DATA_WIDTH  RAM write data.
- ram_data_out  input  DATA_WIDTH  RAM read data.
- ram_out_en  input  1  RAM read-data-valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0; state = IDLE; priority pointer = client 0; timeout counter = 0.
- All outputs are registered. No combinational path from any input to any output.
- States are IDLE, WR and RD.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, that client is selected.
  - If both are high, the client named by the priority pointer wins.
  - At the next edge:
    - load ram_addr, ram_wr_rd and ram_data_in from the winner; set ram_en = 1;
    - pulse the winner's gnt for one cycle;
    - set the pointer to the other client;
    - go to WR if wr_rd = 1, else RD.
  - With no req, stay in IDLE; ram_en = 0.
- WR:
  - Lasts exactly one cycle with ram_en = 1.
  - Then ram_en = 0 and state returns to IDLE.
  - A write therefore occupies 2 cycles, so back-to-back writes issue every 2 cycles.
- RD:
  - ram_en, ram_addr and ram_wr_rd are held stable.
  - The counter increments each cycle in which ram_out_en = 0.
  - If ram_out_en = 1 at an edge:
    - capture ram_data_out into the owner's rdata;
    - pulse the owner's rvalid for one cycle;
    - set ram_en = 0, clear the counter, go to IDLE.
  - If the counter reaches TIMEOUT-1 and ram_out_en = 0 at that edge:
    - set the owner's rdata = 0;
    - pulse the owner's rerr for one cycle;
    - set ram_en = 0, clear the counter, go to IDLE.
  - If ram_out_en = 1 in the same cycle as the timeout expiry, the data wins: rvalid, not rerr.
- ram_out_en is ignored outside RD.
- The pointer updates only on a grant. A lone requester may therefore be granted repeatedly.
- After gnt the client may drop req or present its next command. The new command is not sampled before the arbiter returns to IDLE.
- The non-owning client's gnt, rvalid, rerr and rdata never change during another client's transaction.
- Reset asserted mid-transaction (any state):
  - all outputs clear immediately;
  - the in-flight read is abandoned, with no rvalid or rerr after reset release;
  - the pointer returns to client 0.
- Exactly one of gnt0/gnt1 may be high in any cycle. rvalid and rerr are mutually exclusive per client.

Test Plan:
- r0 write addr 4'h5 data 8'hA5, then r0 read addr 4'h5 against the RAM model -> r0_gnt pulses one cycle after each req is seen; r0_rvalid with r0_rdata = 8'hA5; r1 outputs stay 0.
- r0_req and r1_req both held high from reset with reads to addr 2 and 3 -> grants alternate r0, r1, r0, r1; each rvalid goes to the correct client with data mem[2] and mem[3] respectively.
- Only r1 requests 4 consecutive writes -> 4 r1_gnt pulses spaced 2 cycles apart; ram_en toggles 1,0,1,0.
- RAM model tied ram_out_en = 0, TIMEOUT = 8, r0 read -> r0_rerr after 8 cycles in RD; r0_rdata = 0; busy returns to 0; the next request is served normally.
- RAM model asserts out_en exactly on the 8th RD cycle -> r0_rvalid = 1, r0_rerr = 0.
- rstn pulled low 2 cycles into an r1 read -> all outputs 0 immediately; no r1_rvalid or r1_rerr after release; a subsequent simultaneous request grants r0 first.
